// File: rtl/dcr_regbank_pkg.sv
// Shared definitions for the DCR slave register bank: register offsets,
// CTRL/IRQ bit positions (bit 0 = MSB) and the bus handshake states.
package dcr_regbank_pkg;

   localparam logic [1:0] CTRL_OFF   = 2'd0;
   localparam logic [1:0] STATUS_OFF = 2'd1;
   localparam logic [1:0] EVCNT_OFF  = 2'd2;
   localparam logic [1:0] IRQ_OFF    = 2'd3;

   localparam int unsigned CTRL_CNT_EN = 31;
   localparam int unsigned CTRL_OVF_IE = 30;
   localparam int unsigned CTRL_CMP_IE = 29;

   localparam int unsigned IRQ_OVF = 31;
   localparam int unsigned IRQ_CMP = 30;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACK
   } state_t;

endpackage

// File: rtl/dcr_regbank_evcnt.sv
// 32-bit event counter with parallel load; reports wrap and compare hits
// for the increment taking effect on the current edge.
module dcr_regbank_evcnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [0:31] load_val,
   input  logic        en,
   input  logic [0:15] cmp_val,
   output logic [0:31] count,
   output logic        wrap,
   output logic        cmp_hit
);

   logic        inc;
   logic [0:31] count_inc;

   // A load on the same edge as an event suppresses the increment and its flags.
   always_comb begin
      inc       = en & ~load;
      count_inc = count + 32'd1;
      wrap      = inc & (count == '1);
      cmp_hit   = inc & (count_inc == {16'h0000, cmp_val});
   end

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (inc)
         count <= count_inc;
   end

endmodule

// File: rtl/dcr_slave_regbank.sv
// DCR daisy-chain slave exposing CTRL, STATUS, EVCNT and IRQ registers
// in a four-word window with a configurable acknowledge latency.
module dcr_slave_regbank
   import dcr_regbank_pkg::*;
#(
   parameter logic [0:9]  C_BASEADDR    = 10'h000,
   parameter int unsigned C_ACK_LATENCY = 1,
   parameter logic [0:31] C_CTRL_RESET  = 32'h0000_0000
) (
   input  logic        DCRCLK,
   input  logic        DCRRST,
   input  logic [0:9]  DCRABUS,
   input  logic [0:31] DCRDBUSIN,
   input  logic        DCRREAD,
   input  logic        DCRWRITE,
   output logic        DCRACK,
   output logic [0:31] DCRDBUSOUT,
   input  logic        EVENTIN,
   input  logic [0:15] STATUSIN,
   output logic [0:31] CTRLOUT,
   output logic        IRQOUT
);

   localparam logic [3:0] LAT_LOAD = (C_ACK_LATENCY == 0) ? 4'd0 : 4'(C_ACK_LATENCY - 1);

   state_t      state, state_nxt;
   logic [3:0]  lat_cnt;
   logic [0:1]  off_q;
   logic        wr_q;
   logic [0:15] status_q;
   logic [0:31] ctrl;
   logic        irq_ovf, irq_cmp, irqout_q;
   logic [0:31] evcnt;
   logic        ev_wrap, ev_cmp;

   logic        req, req_ok, sample, enter_ack, wr_fire;
   logic [0:1]  off_sel;
   logic        wr_sel;
   logic        ld_ctrl, ld_evcnt, ld_irq;
   logic [0:31] rd_data;

   assign req    = DCRREAD | DCRWRITE;
   assign req_ok = (DCRREAD ^ DCRWRITE) && (DCRABUS[0:7] == C_BASEADDR[0:7]);
   assign sample = (state == IDLE) && req_ok;

   always_ff @(posedge DCRCLK) begin
      if (DCRRST)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req_ok) state_nxt = (C_ACK_LATENCY == 0) ? ACK : WAIT;
         WAIT: begin
            if (!req)
               state_nxt = IDLE;
            else if (lat_cnt == '0)
               state_nxt = ACK;
         end
         ACK:  if (!req) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // With zero latency the ACK entry edge is also the sample edge, so the
   // offset/direction come straight from the bus rather than the latches.
   always_comb begin
      enter_ack = (state != ACK) && (state_nxt == ACK);
      off_sel   = (state == IDLE) ? DCRABUS[8:9] : off_q;
      wr_sel    = (state == IDLE) ? DCRWRITE : wr_q;
      wr_fire   = enter_ack & wr_sel;
      ld_ctrl   = wr_fire && (off_sel == CTRL_OFF);
      ld_evcnt  = wr_fire && (off_sel == EVCNT_OFF);
      ld_irq    = wr_fire && (off_sel == IRQ_OFF);
   end

   dcr_regbank_evcnt u_evcnt (
      .clk      (DCRCLK),
      .rst      (DCRRST),
      .load     (ld_evcnt),
      .load_val (DCRDBUSIN),
      .en       (EVENTIN & ctrl[CTRL_CNT_EN]),
      .cmp_val  (ctrl[0:15]),
      .count    (evcnt),
      .wrap     (ev_wrap),
      .cmp_hit  (ev_cmp)
   );

   always_ff @(posedge DCRCLK) begin
      if (DCRRST) begin
         lat_cnt  <= '0;
         off_q    <= '0;
         wr_q     <= 1'b0;
         status_q <= '0;
         ctrl     <= C_CTRL_RESET;
         irq_ovf  <= 1'b0;
         irq_cmp  <= 1'b0;
         irqout_q <= 1'b0;
      end else begin
         if (sample) begin
            lat_cnt  <= LAT_LOAD;
            off_q    <= DCRABUS[8:9];
            wr_q     <= DCRWRITE;
            status_q <= STATUSIN;
         end else if ((state == WAIT) && (lat_cnt != '0)) begin
            lat_cnt <= lat_cnt - 4'd1;
         end
         if (ld_ctrl)
            ctrl <= DCRDBUSIN;
         // Set takes priority over a write-1-to-clear on the same edge.
         irq_ovf  <= (irq_ovf & ~(ld_irq & DCRDBUSIN[IRQ_OVF])) | ev_wrap;
         irq_cmp  <= (irq_cmp & ~(ld_irq & DCRDBUSIN[IRQ_CMP])) | ev_cmp;
         irqout_q <= (irq_ovf & ctrl[CTRL_OVF_IE]) | (irq_cmp & ctrl[CTRL_CMP_IE]);
      end
   end

   always_comb begin
      rd_data = '0;
      case (off_q)
         CTRL_OFF:   rd_data = ctrl;
         STATUS_OFF: rd_data = {status_q, 16'h0000};
         EVCNT_OFF:  rd_data = evcnt;
         IRQ_OFF: begin
            rd_data[IRQ_OVF] = irq_ovf;
            rd_data[IRQ_CMP] = irq_cmp;
         end
         default: rd_data = '0;
      endcase
   end

   assign DCRACK     = (state == ACK);
   assign DCRDBUSOUT = (state == ACK) ? rd_data : DCRDBUSIN;
   assign CTRLOUT    = ctrl;
   assign IRQOUT     = irqout_q;

endmodule

// File: tb/tb_dcr_slave_regbank.sv
// Self-checking bench for dcr_slave_regbank: directed scenarios followed by
// random transactions, compared against a register-level reference model.
module tb_dcr_slave_regbank;

   localparam logic [9:0]  BASE = 10'h080;
   localparam logic [31:0] CRST = 32'h0000_00F0;

   logic        DCRCLK = 1'b0;
   logic        DCRRST, DCRREAD, DCRWRITE, EVENTIN;
   logic [9:0]  DCRABUS;
   logic [31:0] DCRDBUSIN;
   logic [15:0] STATUSIN;
   logic        DCRACK, IRQOUT;
   logic [31:0] DCRDBUSOUT, CTRLOUT;

   int unsigned errors = 0;
   int unsigned checks = 0;
   bit          ev_rand = 1'b0;

   // Reference model; tb bit k corresponds to bus bit 31-k.
   logic [31:0] m_ctrl, m_evcnt;
   logic        m_ovf, m_cmp, m_irqout;
   logic [15:0] m_status;

   dcr_slave_regbank #(
      .C_BASEADDR   (BASE),
      .C_ACK_LATENCY(1),
      .C_CTRL_RESET (CRST)
   ) dut (
      .DCRCLK    (DCRCLK),
      .DCRRST    (DCRRST),
      .DCRABUS   (DCRABUS),
      .DCRDBUSIN (DCRDBUSIN),
      .DCRREAD   (DCRREAD),
      .DCRWRITE  (DCRWRITE),
      .DCRACK    (DCRACK),
      .DCRDBUSOUT(DCRDBUSOUT),
      .EVENTIN   (EVENTIN),
      .STATUSIN  (STATUSIN),
      .CTRLOUT   (CTRLOUT),
      .IRQOUT    (IRQOUT)
   );

   always #5 DCRCLK = ~DCRCLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_reg(input logic [1:0] off);
      case (off)
         2'd0:    return m_ctrl;
         2'd1:    return {m_status, 16'h0000};
         2'd2:    return m_evcnt;
         default: return {30'h0, m_cmp, m_ovf};
      endcase
   endfunction

   // Applies one clock edge to the model using the inputs present at that edge.
   task automatic model_edge(input bit wfire);
      logic        wr_c, wr_e, wr_i, inc, set_ovf, set_cmp, irq_n;
      logic [31:0] nxt;
      if (DCRRST) begin
         m_ctrl = CRST; m_evcnt = '0; m_ovf = 1'b0; m_cmp = 1'b0;
         m_irqout = 1'b0; m_status = '0;
      end else begin
         wr_c    = wfire && (DCRABUS[1:0] == 2'd0);
         wr_e    = wfire && (DCRABUS[1:0] == 2'd2);
         wr_i    = wfire && (DCRABUS[1:0] == 2'd3);
         irq_n   = (m_ovf & m_ctrl[1]) | (m_cmp & m_ctrl[2]);
         inc     = EVENTIN && m_ctrl[0] && !wr_e;
         nxt     = m_evcnt + 32'd1;
         set_ovf = inc && (m_evcnt == 32'hFFFF_FFFF);
         set_cmp = inc && (nxt == {16'h0000, m_ctrl[31:16]});
         if (inc)  m_evcnt = nxt;
         if (wr_e) m_evcnt = DCRDBUSIN;
         if (wr_c) m_ctrl  = DCRDBUSIN;
         m_ovf    = (m_ovf & ~(wr_i & DCRDBUSIN[0])) | set_ovf;
         m_cmp    = (m_cmp & ~(wr_i & DCRDBUSIN[1])) | set_cmp;
         m_irqout = irq_n;
      end
   endtask

   task automatic clk_edge(input bit wfire);
      @(posedge DCRCLK);
      model_edge(wfire);
      #1;
   endtask

   task automatic drive_ev(input bit force1);
      EVENTIN = force1 ? 1'b1 : (ev_rand ? 1'($urandom_range(0, 1)) : 1'b0);
   endtask

   task automatic chk_outs();
      chk("ctrlout", CTRLOUT, m_ctrl);
      chk("irqout", 32'(IRQOUT), 32'(m_irqout));
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         drive_ev(1'b0);
         DCRDBUSIN = $urandom;
         clk_edge(1'b0);
         chk("idle_ack", 32'(DCRACK), 32'd0);
         chk("idle_pass", DCRDBUSOUT, DCRDBUSIN);
      end
      chk_outs();
   endtask

   task automatic dcr_xfer(input bit is_wr, input logic [1:0] off, input logic [31:0] data,
                           input int unsigned hold, input bit ev_hold, output logic [31:0] rdata);
      DCRABUS   = {BASE[9:2], off};
      DCRDBUSIN = is_wr ? data : $urandom;
      DCRREAD   = !is_wr;
      DCRWRITE  = is_wr;
      STATUSIN  = 16'($urandom);
      m_status  = STATUSIN;
      drive_ev(ev_hold);
      clk_edge(1'b0);
      chk("xfer_wait_noack", 32'(DCRACK), 32'd0);
      drive_ev(ev_hold);
      clk_edge(is_wr);
      chk("xfer_ack", 32'(DCRACK), 32'd1);
      rdata = DCRDBUSOUT;
      if (!is_wr) chk("rdata", DCRDBUSOUT, m_reg(off));
      for (int unsigned i = 0; i < hold; i++) begin
         drive_ev(ev_hold);
         clk_edge(1'b0);
         chk("hold_ack", 32'(DCRACK), 32'd1);
      end
      DCRREAD   = 1'b0;
      DCRWRITE  = 1'b0;
      DCRDBUSIN = $urandom;
      drive_ev(1'b0);
      clk_edge(1'b0);
      chk("ack_drop", 32'(DCRACK), 32'd0);
      chk("drop_pass", DCRDBUSOUT, DCRDBUSIN);
      chk_outs();
   endtask

   initial begin
      logic [31:0] rd, data;
      logic [1:0]  off;
      bit          isw;

      DCRRST = 1'b1; DCRREAD = 1'b0; DCRWRITE = 1'b0; EVENTIN = 1'b0;
      DCRABUS = '0; DCRDBUSIN = 32'hDEAD_BEEF; STATUSIN = '0;
      repeat (3) clk_edge(1'b0);
      DCRRST = 1'b0;
      chk("rst_ack", 32'(DCRACK), 32'd0);
      chk("rst_ctrl", CTRLOUT, CRST);
      chk("rst_irqout", 32'(IRQOUT), 32'd0);
      chk("rst_pass", DCRDBUSOUT, 32'hDEAD_BEEF);

      // CTRL write then read back
      dcr_xfer(1'b1, 2'd0, 32'hA5A5_0007, 0, 1'b0, rd);
      chk("ctrl_wr", CTRLOUT, 32'hA5A5_0007);
      dcr_xfer(1'b0, 2'd0, '0, 0, 1'b0, rd);
      chk("ctrl_rd", rd, 32'hA5A5_0007);

      // Address outside the window
      DCRABUS = 10'h100; DCRREAD = 1'b1; DCRDBUSIN = 32'h1234_5678;
      repeat (20) begin
         clk_edge(1'b0);
         chk("nomatch_ack", 32'(DCRACK), 32'd0);
         chk("nomatch_pass", DCRDBUSOUT, 32'h1234_5678);
      end
      DCRREAD = 1'b0;

      // Read and write both high
      DCRABUS = {BASE[9:2], 2'd0}; DCRREAD = 1'b1; DCRWRITE = 1'b1; DCRDBUSIN = 32'hFFFF_0000;
      repeat (5) begin
         clk_edge(1'b0);
         chk("both_ack", 32'(DCRACK), 32'd0);
         chk("both_pass", DCRDBUSOUT, 32'hFFFF_0000);
      end
      DCRREAD = 1'b0; DCRWRITE = 1'b0;
      idle(1);

      // Request dropped while waiting
      DCRWRITE = 1'b1; DCRDBUSIN = 32'h0BAD_0BAD; m_status = STATUSIN;
      clk_edge(1'b0);
      DCRWRITE = 1'b0;
      clk_edge(1'b0);
      chk("abort_ack", 32'(DCRACK), 32'd0);
      idle(2);
      chk("abort_ctrl", CTRLOUT, 32'hA5A5_0007);

      // Overflow and W1C
      dcr_xfer(1'b1, 2'd0, 32'h0000_0003, 0, 1'b0, rd);
      dcr_xfer(1'b1, 2'd2, 32'hFFFF_FFFE, 0, 1'b0, rd);
      EVENTIN = 1'b1; clk_edge(1'b0); clk_edge(1'b0); EVENTIN = 1'b0;
      chk("ovf_irqout_lag", 32'(IRQOUT), 32'd0);
      clk_edge(1'b0);
      chk("ovf_irqout", 32'(IRQOUT), 32'd1);
      dcr_xfer(1'b0, 2'd2, '0, 0, 1'b0, rd);
      chk("ovf_cnt", rd, 32'd0);
      dcr_xfer(1'b0, 2'd3, '0, 0, 1'b0, rd);
      chk("ovf_flag", rd & 32'h1, 32'h1);
      dcr_xfer(1'b1, 2'd3, 32'h0000_0001, 0, 1'b0, rd);
      idle(2);
      chk("irq_cleared", 32'(IRQOUT), 32'd0);

      // Write beats a simultaneous increment
      dcr_xfer(1'b1, 2'd0, 32'h0000_0001, 0, 1'b0, rd);
      dcr_xfer(1'b1, 2'd2, 32'h0000_0010, 0, 1'b1, rd);
      dcr_xfer(1'b0, 2'd2, '0, 0, 1'b0, rd);
      chk("wr_wins", rd, 32'h0000_0010);

      // Master holds the request after ack: one write only
      dcr_xfer(1'b1, 2'd2, 32'h0000_0100, 5, 1'b1, rd);
      dcr_xfer(1'b0, 2'd2, '0, 5, 1'b0, rd);
      chk("hold_once", rd, 32'h0000_0105);

      // Reset while waiting
      DCRABUS = {BASE[9:2], 2'd0}; DCRWRITE = 1'b1; DCRDBUSIN = 32'h7777_7777; m_status = STATUSIN;
      clk_edge(1'b0);
      chk("rstw_wait", 32'(DCRACK), 32'd0);
      DCRRST = 1'b1;
      clk_edge(1'b0);
      chk("rstw_ack", 32'(DCRACK), 32'd0);
      chk("rstw_ctrl", CTRLOUT, CRST);
      DCRRST = 1'b0; DCRWRITE = 1'b0;
      idle(1);
      dcr_xfer(1'b1, 2'd0, 32'h0000_1235, 0, 1'b0, rd);
      chk("post_rst_wr", CTRLOUT, 32'h0000_1235);

      // Random traffic with random events
      ev_rand = 1'b1;
      for (int i = 0; i < 60; i++) begin
         off  = 2'($urandom_range(0, 3));
         isw  = 1'($urandom_range(0, 1));
         data = $urandom;
         if (off == 2'd0) data[31:16] = 16'($urandom_range(0, 40));
         if (off == 2'd2) data = ($urandom_range(0, 1) != 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                              : 32'($urandom_range(0, 30));
         dcr_xfer(isw, off, data, $urandom_range(0, 3), 1'b0, rd);
         idle($urandom_range(0, 3));
      end
      ev_rand = 1'b0;
      idle(2);
      for (int k = 0; k < 4; k++) dcr_xfer(1'b0, 2'(k), '0, 0, 1'b0, rd);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
